fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-cycle synchronous imem, stall hold and redirect.
// Define FETCH_PERF_COUNTERS_EN to build the stall/flush performance counters.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_to_d_enable,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] fd_instr,
    output logic [XLEN-1:0] fd_pc,
    output logic            fd_valid,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        FLUSH
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] issued_pc;
    logic [XLEN-1:0] issued_next;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic            hold_load;

    assign imem_addr = pc;

    // Next-state, next-PC and decode-facing outputs; a redirect overrides everything else.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        issued_next = issued_pc;
        hold_load   = 1'b0;
        imem_rd_en  = 1'b0;
        fd_instr    = NOP_INSTR;
        fd_pc       = pc;
        fd_valid    = 1'b0;
        case (state)
            BOOT, FLUSH: begin
                imem_rd_en  = 1'b1;
                pc_next     = pc + PC_STEP;
                issued_next = pc;
                state_next  = RUN;
            end
            RUN: begin
                fd_instr = imem_rdata;
                fd_pc    = issued_pc;
                fd_valid = 1'b1;
                if (f_to_d_enable) begin
                    imem_rd_en  = 1'b1;
                    pc_next     = pc + PC_STEP;
                    issued_next = pc;
                end else begin
                    hold_load  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                fd_instr   = hold_instr;
                fd_pc      = hold_pc;
                fd_valid   = 1'b1;
                imem_rd_en = f_to_d_enable;
                if (f_to_d_enable) begin
                    pc_next     = pc + PC_STEP;
                    issued_next = pc;
                    state_next  = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        if (branch_taken) begin
            pc_next    = {branch_target[XLEN-1:2], 2'b00};
            state_next = FLUSH;
        end
    end

    // State, PC and hold registers; the hold copy is captured as decode stalls in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            issued_pc  <= '0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            issued_pc <= issued_next;
            if (branch_taken) begin
                hold_instr <= NOP_INSTR;
                hold_pc    <= '0;
            end else if (hold_load) begin
                hold_instr <= fd_instr;
                hold_pc    <= fd_pc;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic stall_event;

    assign stall_event = ((state == RUN) || (state == HOLD)) && !f_to_d_enable;

    // Saturating counts of decode-stall cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_event && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
